// File: rtl/pkt_stream_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS ingress packet streams into one output channel.
// Define ARB_PKT_STATS_EN to build the per-port forwarded-packet counters.
`ifndef PARSER_WIN_SIZE_BYTES
`define PARSER_WIN_SIZE_BYTES 8
`endif

module pkt_stream_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIN_BYTES = `PARSER_WIN_SIZE_BYTES,
  parameter int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PORTS-1:0]                   in_valid,
  input  logic [NUM_PORTS-1:0]                   in_sop,
  input  logic [NUM_PORTS-1:0]                   in_eop,
  input  logic [NUM_PORTS-1:0][WIN_BYTES*8-1:0]  in_data,
  output logic [NUM_PORTS-1:0]                   in_ready,
  output logic                                   out_valid,
  output logic                                   out_sop,
  output logic                                   out_eop,
  output logic [WIN_BYTES*8-1:0]                 out_data,
  output logic [PORT_W-1:0]                      out_port,
  input  logic                                   out_ready,
  output logic [15:0]                            err_drop_cnt,
  output logic [NUM_PORTS-1:0][31:0]             pkt_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state;
  logic [PORT_W-1:0]   owner;
  logic [PORT_W-1:0]   last_grant;

  logic                slot_free;
  logic                win_found;
  logic [PORT_W-1:0]   win;
  logic [PORT_W-1:0]   scan;
  logic [NUM_PORTS-1:0] stray;
  logic [NUM_PORTS-1:0] ready;
  logic                load;
  logic [PORT_W-1:0]   src;
  logic [3:0]          drop_n;
  logic [16:0]         drop_sum;

  always_comb begin
    slot_free = ~out_valid | out_ready;

    // Rotating priority: search starts just after the last granted port.
    win_found = 1'b0;
    win       = '0;
    scan      = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      scan = PORT_W'((32'(last_grant) + i) % NUM_PORTS);
      if (!win_found && in_valid[scan] && in_sop[scan]) begin
        win_found = 1'b1;
        win       = scan;
      end
    end

    ready = '0;
    stray = '0;
    load  = 1'b0;
    src   = owner;
    if (state == IDLE) begin
      // Stray beats are swallowed even while the output slot is stalled.
      stray = in_valid & ~in_sop;
      ready = stray;
      if (win_found && slot_free) begin
        ready[win] = 1'b1;
        load       = 1'b1;
        src        = win;
      end
    end else begin
      ready[owner] = slot_free;
      if (slot_free && in_valid[owner]) begin
        load = 1'b1;
        src  = owner;
      end
    end

    drop_n = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      drop_n = drop_n + 4'(stray[i]);
    end
    drop_sum = {1'b0, err_drop_cnt} + 17'(drop_n);
  end

  assign in_ready = ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= '0;
      last_grant   <= PORT_W'(NUM_PORTS - 1);
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
      out_port     <= '0;
      err_drop_cnt <= '0;
    end else begin
      err_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      if (load) begin
        out_valid <= 1'b1;
        out_sop   <= in_sop[src];
        out_eop   <= in_eop[src];
        out_data  <= in_data[src];
        out_port  <= src;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load) begin
            owner      <= win;
            last_grant <= win;
            if (!in_eop[win]) state <= BUSY;
          end
        end
        BUSY: begin
          if (load && in_eop[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt <= '0;
    end else if (load && in_eop[src]) begin
      pkt_cnt[src] <= pkt_cnt[src] + 32'd1;
    end
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule
